// File: rtl/uart_sort_buffer_if.sv
// uart_sort_buffer_if
// Groups the RX-side, TX-side and status signals of the sort buffer into one bundle.
//   i_Rx_DV / i_Rx_Byte   : byte strobe and data coming from the UART receiver
//   o_Tx_DV / o_Tx_Byte   : start strobe and data going to the UART transmitter
//   i_Tx_Done             : transmitter finished the current byte
//   o_Busy                : buffer is sorting or sending
//   o_Rx_Drop             : an incoming byte was discarded
// slave modport  : used by uart_sort_buffer
// master modport : used by whatever drives the buffer (receiver/transmitter side)
interface uart_sort_buffer_if #(
  parameter int WIDTH = 8
);
  logic             i_Rx_DV;
  logic [WIDTH-1:0] i_Rx_Byte;
  logic             o_Tx_DV;
  logic [WIDTH-1:0] o_Tx_Byte;
  logic             i_Tx_Done;
  logic             o_Busy;
  logic             o_Rx_Drop;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Busy, o_Rx_Drop
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Busy, o_Rx_Drop
  );
endinterface

// File: rtl/uart_sort_buffer.sv
// uart_sort_buffer
// Collects DEPTH bytes from the UART receiver, bubble-sorts them in place
// (one compare-and-swap per clock), then streams them to the UART transmitter
// with a DV/Done handshake.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous assert, active-low reset
//   bus       : uart_sort_buffer_if.slave (RX strobe/byte, TX strobe/byte/done,
//               busy and drop status)
// Build option:
//   UART_SORT_DESCENDING_EN : when defined, output order is descending
//                             (timing unchanged); ascending otherwise.
module uart_sort_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input logic                i_clock,
  input logic                i_reset_n,
  uart_sort_buffer_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SORT    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] count_reg;
  logic [IDX_W-1:0] k_reg;
  logic [IDX_W-1:0] p_reg;
  logic [IDX_W-1:0] j_reg;
  logic             swapped_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             tx_dv_reg;
  logic [WIDTH-1:0] tx_byte_reg;
  logic             rx_drop_reg;

  logic [IDX_W-1:0] j_plus1;
  logic [IDX_W-1:0] k_plus1;
  logic [IDX_W-1:0] last_j;
  logic [WIDTH-1:0] elem_lo;
  logic [WIDTH-1:0] elem_hi;
  logic             do_swap;
  logic             pass_end;
  logic             sort_done;
  logic [WIDTH-1:0] first_out;

  always_comb begin
    j_plus1  = j_reg + IDX_W'(1);
    k_plus1  = k_reg + IDX_W'(1);
    last_j   = LAST_PASS - p_reg;
    elem_lo  = mem[j_reg];
    elem_hi  = mem[j_plus1];
`ifdef UART_SORT_DESCENDING_EN
    do_swap  = (elem_lo < elem_hi);
`else
    do_swap  = (elem_lo > elem_hi);
`endif
    pass_end = (j_reg == last_j);
    // A swap on this very compare still counts as "the pass swapped".
    sort_done = pass_end && (!(swapped_reg || do_swap) || (p_reg == LAST_PASS));
    // mem[0] is still being updated on the final compare, so the first output
    // byte must reflect a swap happening in the same cycle at j==0.
    first_out = (do_swap && (j_reg == '0)) ? elem_hi : mem[0];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= S_COLLECT;
      count_reg   <= '0;
      k_reg       <= '0;
      p_reg       <= '0;
      j_reg       <= '0;
      swapped_reg <= 1'b0;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= '0;
      rx_drop_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      tx_dv_reg   <= 1'b0;
      rx_drop_reg <= bus.i_Rx_DV && (state_reg != S_COLLECT);

      case (state_reg)
        S_COLLECT: begin
          if (bus.i_Rx_DV) begin
            mem[count_reg] <= bus.i_Rx_Byte;
            if (count_reg == LAST_IDX) begin
              state_reg   <= S_SORT;
              count_reg   <= '0;
              p_reg       <= '0;
              j_reg       <= '0;
              swapped_reg <= 1'b0;
            end else begin
              count_reg <= count_reg + IDX_W'(1);
            end
          end
        end

        S_SORT: begin
          if (do_swap) begin
            mem[j_reg]   <= elem_hi;
            mem[j_plus1] <= elem_lo;
            swapped_reg  <= 1'b1;
          end
          if (pass_end) begin
            if (sort_done) begin
              state_reg   <= S_SEND;
              k_reg       <= '0;
              tx_dv_reg   <= 1'b1;
              tx_byte_reg <= first_out;
            end else begin
              p_reg       <= p_reg + IDX_W'(1);
              j_reg       <= '0;
              swapped_reg <= 1'b0;
            end
          end else begin
            j_reg <= j_plus1;
          end
        end

        S_SEND: begin
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.i_Tx_Done) begin
            if (k_reg == LAST_IDX) begin
              state_reg <= S_COLLECT;
            end else begin
              k_reg       <= k_plus1;
              state_reg   <= S_SEND;
              tx_dv_reg   <= 1'b1;
              tx_byte_reg <= mem[k_plus1];
            end
          end
        end

        default: state_reg <= S_COLLECT;
      endcase
    end
  end

  assign bus.o_Tx_DV   = tx_dv_reg;
  assign bus.o_Tx_Byte = tx_byte_reg;
  assign bus.o_Busy    = (state_reg != S_COLLECT);
  assign bus.o_Rx_Drop = rx_drop_reg;

endmodule

// File: tb/tb_uart_sort_buffer.sv
module tb_uart_sort_buffer;

  logic i_clock;
  logic i_reset_n;

  uart_sort_buffer_if #(.WIDTH(8)) bus();

  uart_sort_buffer #(.DEPTH(8), .WIDTH(8)) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [7:0][7:0] din;
    logic [7:0][7:0] dexp;
    int              lat;
  } vec_t;

  vec_t vecs[4];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t_last   = 0;

  function automatic logic [7:0][7:0] pack8(input logic [7:0] a0, a1, a2, a3,
                                            a4, a5, a6, a7);
    logic [7:0][7:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  task automatic step();
    @(posedge i_clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_batch(input logic [7:0][7:0] b);
    for (int i = 0; i < 8; i++) begin
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = b[i];
      step();
    end
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    t_last = cyc - 1;
    $display("rx batch sent, last byte sampled in cycle %0d", t_last);
  endtask

  task automatic recv_batch(input logic [7:0][7:0] exp, input int lat_exp,
                            input int stop_after, input bit dv_on_last);
    int n;
    int pulses;
    bit extra;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (bus.o_Tx_DV !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      if (bus.o_Tx_DV !== 1'b1) begin
        chk("tx_dv_timeout", 32'd0, 32'd1);
        return;
      end
      if (i == 0 && lat_exp >= 0) chk("first_dv_latency", cyc - t_last, lat_exp);
      pulses++;
      $display("tx byte %0d: got 0x%02h expect 0x%02h (cycle %0d)", i, bus.o_Tx_Byte, exp[i], cyc);
      chk("tx_byte", bus.o_Tx_Byte, exp[i]);
      step();
      chk("tx_dv_single", bus.o_Tx_DV, 1'b0);
      chk("tx_byte_hold", bus.o_Tx_Byte, exp[i]);
      chk("busy_in_wait", bus.o_Busy, 1'b1);
      bus.i_Tx_Done = 1'b1;
      if (dv_on_last && i == 7) begin
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = 8'h55;
      end
      step();
      bus.i_Tx_Done = 1'b0;
      bus.i_Rx_DV   = 1'b0;
      bus.i_Rx_Byte = 8'h00;
      if (stop_after == i + 1) return;
    end
    chk("tx_pulses", pulses, 8);
    chk("busy_after_batch", bus.o_Busy, 1'b0);
    if (dv_on_last) chk("boundary_drop", bus.o_Rx_Drop, 1'b1);
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.o_Tx_DV === 1'b1) extra = 1'b1;
    end
    chk("no_extra_tx_dv", extra, 1'b0);
  endtask

  initial begin
    logic [7:0][7:0] rev_exp;

    vecs[0].din = pack8(8'h35, 8'h02, 8'hFF, 8'h10, 8'h80, 8'h00, 8'h7E, 8'h10);
    vecs[1].din = pack8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
    vecs[2].din = pack8(8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
    vecs[3].din = pack8(8'h09, 8'h03, 8'h03, 8'h01, 8'h05, 8'h02, 8'h07, 8'h04);
`ifdef UART_SORT_DESCENDING_EN
    vecs[0].dexp = pack8(8'hFF, 8'h80, 8'h7E, 8'h35, 8'h10, 8'h10, 8'h02, 8'h00);
    vecs[1].dexp = pack8(8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
    vecs[2].dexp = vecs[1].dexp;
    vecs[3].dexp = pack8(8'h09, 8'h07, 8'h05, 8'h04, 8'h03, 8'h03, 8'h02, 8'h01);
    vecs[1].lat  = 29;
    vecs[2].lat  = 8;
`else
    vecs[0].dexp = pack8(8'h00, 8'h02, 8'h10, 8'h10, 8'h35, 8'h7E, 8'h80, 8'hFF);
    vecs[1].dexp = pack8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
    vecs[2].dexp = vecs[1].dexp;
    vecs[3].dexp = pack8(8'h01, 8'h02, 8'h03, 8'h03, 8'h04, 8'h05, 8'h07, 8'h09);
    vecs[1].lat  = 8;
    vecs[2].lat  = 29;
`endif
    vecs[0].lat = -1;
    vecs[3].lat = -1;
    rev_exp = vecs[2].dexp;

    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Tx_Done = 1'b0;
    i_reset_n     = 1'b0;
    step();
    step();
    chk("reset_tx_dv", bus.o_Tx_DV, 1'b0);
    chk("reset_tx_byte", bus.o_Tx_Byte, 8'h00);
    chk("reset_busy", bus.o_Busy, 1'b0);
    chk("reset_rx_drop", bus.o_Rx_Drop, 1'b0);
    i_reset_n = 1'b1;
    step();

    // Table-driven batches: ascending mix, sorted input, reverse input.
    for (int v = 0; v < 3; v++) begin
      send_batch(vecs[v].din);
      chk("busy_after_last_dv", bus.o_Busy, 1'b1);
      chk("no_drop_in_collect", bus.o_Rx_Drop, 1'b0);
      recv_batch(vecs[v].dexp, vecs[v].lat, 0, 1'b0);
    end

    // Byte arriving mid-sort is dropped; byte at the batch boundary is dropped.
    send_batch(vecs[2].din);
    step();
    step();
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'hAA;
    step();
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    $display("drop test: 0xAA pulsed during sort, rx_drop=%0b (cycle %0d)", bus.o_Rx_Drop, cyc);
    chk("drop_pulse", bus.o_Rx_Drop, 1'b1);
    step();
    chk("drop_one_cycle", bus.o_Rx_Drop, 1'b0);
    recv_batch(rev_exp, -1, 0, 1'b1);

    // Tx_Done while collecting does nothing.
    bus.i_Tx_Done = 1'b1;
    step();
    bus.i_Tx_Done = 1'b0;
    chk("done_in_collect_busy", bus.o_Busy, 1'b0);
    chk("done_in_collect_dv", bus.o_Tx_DV, 1'b0);
    step();

    // Boundary-dropped byte must not have started a batch: this one is intact.
    send_batch(vecs[0].din);
    recv_batch(vecs[0].dexp, -1, 3, 1'b0);

    // Asynchronous reset after the 3rd Tx_Done.
    i_reset_n = 1'b0;
    #1;
    $display("reset asserted mid-send: tx_dv=%0b tx_byte=0x%02h busy=%0b", bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Busy);
    chk("async_reset_tx_dv", bus.o_Tx_DV, 1'b0);
    chk("async_reset_tx_byte", bus.o_Tx_Byte, 8'h00);
    chk("async_reset_busy", bus.o_Busy, 1'b0);
    step();
    step();
    i_reset_n = 1'b1;
    step();

    send_batch(vecs[3].din);
    recv_batch(vecs[3].dexp, vecs[3].lat, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
